// File: rtl/pzcorebus_request_aligner.sv
// Request aligner: holds a write's data beats until its command has been
// accepted downstream, counts the burst, flags the last beat, and blocks the
// next command until the current burst has fully drained.
module pzcorebus_request_aligner #(
  parameter int CMD_WIDTH    = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int LENGTH_WIDTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_mcmd_valid,
  output logic                    o_scmd_accept,
  input  logic                    i_mcmd_write,
  input  logic [LENGTH_WIDTH-1:0] i_mcmd_length,
  input  logic [CMD_WIDTH-1:0]    i_mcmd,
  input  logic                    i_mdata_valid,
  output logic                    o_sdata_accept,
  input  logic [DATA_WIDTH-1:0]   i_mdata,
  output logic                    o_mcmd_valid,
  input  logic                    i_scmd_accept,
  output logic                    o_mcmd_write,
  output logic [LENGTH_WIDTH-1:0] o_mcmd_length,
  output logic [CMD_WIDTH-1:0]    o_mcmd,
  output logic                    o_mdata_valid,
  input  logic                    i_sdata_accept,
  output logic [DATA_WIDTH-1:0]   o_mdata,
  output logic                    o_mdata_last,
  output logic                    o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [LENGTH_WIDTH:0] ONE = {{LENGTH_WIDTH{1'b0}}, 1'b1};

  state_t                  state;
  logic [LENGTH_WIDTH:0]   count;
  logic                    mcmd_write;
  logic [LENGTH_WIDTH-1:0] mcmd_length;
  logic [CMD_WIDTH-1:0]    mcmd;

  logic [LENGTH_WIDTH:0]   beats;
  logic [LENGTH_WIDTH:0]   last_index;
  logic                    in_data;
  logic                    beat_done;
  logic                    last_beat;

  // Burst length decode: a length of zero means the full 2**LENGTH_WIDTH beats,
  // which the extra counter bit can represent without wrapping.
  always_comb begin
    beats      = (mcmd_length == '0) ? {1'b1, {LENGTH_WIDTH{1'b0}}}
                                     : {1'b0, mcmd_length};
    last_index = beats - ONE;
    in_data    = (state == DATA);
    beat_done  = in_data && i_mdata_valid && i_sdata_accept;
    last_beat  = (count == last_index);
  end

  // Command capture, state sequencing and beat counting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      count       <= '0;
      mcmd_write  <= 1'b0;
      mcmd_length <= '0;
      mcmd        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_mcmd_valid) begin
            mcmd_write  <= i_mcmd_write;
            mcmd_length <= i_mcmd_length;
            mcmd        <= i_mcmd;
            state       <= CMD;
          end
        end
        CMD: begin
          if (i_scmd_accept) begin
            if (mcmd_write) begin
              count <= '0;
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (beat_done) begin
            count <= count + ONE;
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake gating: data passes straight through only while in DATA;
  // otherwise upstream sees no accept and its data is held.
  always_comb begin
    o_scmd_accept  = (state == IDLE);
    o_mcmd_valid   = (state == CMD);
    o_mcmd_write   = mcmd_write;
    o_mcmd_length  = mcmd_length;
    o_mcmd         = mcmd;
    o_mdata_valid  = in_data && i_mdata_valid;
    o_sdata_accept = in_data && i_sdata_accept;
    o_mdata        = in_data ? i_mdata : '0;
    o_mdata_last   = in_data && last_beat;
    o_busy         = (state != IDLE);
  end

endmodule

// File: tb/tb_pzcorebus_request_aligner.sv
// Directed bench for pzcorebus_request_aligner: a per-cycle vector table for
// the basic read and write flows, then hand-written multi-cycle sequences.
module tb_pzcorebus_request_aligner;

  localparam int CW = 32;
  localparam int DW = 64;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mv, mw, sa_c, dv, da;
  logic [LW-1:0] ml;
  logic [CW-1:0] mc;
  logic [DW-1:0] d;

  logic          o_scmd_accept, o_sdata_accept, o_mcmd_valid, o_mcmd_write;
  logic [LW-1:0] o_mcmd_length;
  logic [CW-1:0] o_mcmd;
  logic          o_mdata_valid, o_mdata_last, o_busy;
  logic [DW-1:0] o_mdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pzcorebus_request_aligner #(
    .CMD_WIDTH    (CW),
    .DATA_WIDTH   (DW),
    .LENGTH_WIDTH (LW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_mcmd_valid   (mv),
    .o_scmd_accept  (o_scmd_accept),
    .i_mcmd_write   (mw),
    .i_mcmd_length  (ml),
    .i_mcmd         (mc),
    .i_mdata_valid  (dv),
    .o_sdata_accept (o_sdata_accept),
    .i_mdata        (d),
    .o_mcmd_valid   (o_mcmd_valid),
    .i_scmd_accept  (sa_c),
    .o_mcmd_write   (o_mcmd_write),
    .o_mcmd_length  (o_mcmd_length),
    .o_mcmd         (o_mcmd),
    .o_mdata_valid  (o_mdata_valid),
    .i_sdata_accept (da),
    .o_mdata        (o_mdata),
    .o_mdata_last   (o_mdata_last),
    .o_busy         (o_busy)
  );

  typedef struct {
    logic          mv, mw;
    logic [LW-1:0] ml;
    logic [CW-1:0] mc;
    logic          sa_c, dv;
    logic [DW-1:0] d;
    logic          da;
    logic          e_sacc, e_mv;
    logic [CW-1:0] e_mc;
    logic          e_mw;
    logic [LW-1:0] e_ml;
    logic          e_dv, e_dacc;
    logic [DW-1:0] e_d;
    logic          e_last, e_busy;
  } vec_t;

  localparam int NV = 11;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int beat;
    int cyc;
    logic [DW-1:0] ed;

    rst = 1'b1; mv = 0; mw = 0; ml = '0; mc = '0; sa_c = 0; dv = 0; d = '0; da = 0;

    // Inputs                                          | expected outputs
    //      mv mw ml mc            sa dv d                 da  sacc mv mc            mw ml dv dacc d                      last busy
    vec[0]  = '{0, 0, 0, 32'h0,          0, 0, 64'h0,                 0,  1, 0, 32'h0,          0, 0, 0, 0, 64'h0,                 0, 0};
    vec[1]  = '{1, 0, 3, 32'hA5A5_0001,  1, 0, 64'h0,                 0,  1, 0, 32'h0,          0, 0, 0, 0, 64'h0,                 0, 0};
    vec[2]  = '{0, 0, 0, 32'h0,          1, 0, 64'h0,                 0,  0, 1, 32'hA5A5_0001,  0, 3, 0, 0, 64'h0,                 0, 1};
    vec[3]  = '{0, 0, 0, 32'h0,          0, 0, 64'h0,                 0,  1, 0, 32'h0,          0, 0, 0, 0, 64'h0,                 0, 0};
    vec[4]  = '{1, 1, 4, 32'hC0DE_0004,  0, 1, 64'h1111_0000_0000_00D0, 1, 1, 0, 32'h0,          0, 0, 0, 0, 64'h0,                 0, 0};
    vec[5]  = '{0, 0, 0, 32'h0,          1, 1, 64'h1111_0000_0000_00D0, 1, 0, 1, 32'hC0DE_0004,  1, 4, 0, 0, 64'h0,                 0, 1};
    vec[6]  = '{0, 0, 0, 32'h0,          0, 1, 64'h1111_0000_0000_00D0, 1, 0, 0, 32'h0,          0, 0, 1, 1, 64'h1111_0000_0000_00D0, 0, 1};
    vec[7]  = '{0, 0, 0, 32'h0,          0, 1, 64'h1111_0000_0000_00D1, 1, 0, 0, 32'h0,          0, 0, 1, 1, 64'h1111_0000_0000_00D1, 0, 1};
    vec[8]  = '{0, 0, 0, 32'h0,          0, 1, 64'h1111_0000_0000_00D2, 1, 0, 0, 32'h0,          0, 0, 1, 1, 64'h1111_0000_0000_00D2, 0, 1};
    vec[9]  = '{0, 0, 0, 32'h0,          0, 1, 64'h1111_0000_0000_00D3, 1, 0, 0, 32'h0,          0, 0, 1, 1, 64'h1111_0000_0000_00D3, 1, 1};
    vec[10] = '{0, 0, 0, 32'h0,          0, 1, 64'h1111_0000_0000_00D4, 1, 1, 0, 32'h0,          0, 0, 0, 0, 64'h0,                 0, 0};

    // Reset state, observed while reset is still held.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst.scmd_accept",  64'(o_scmd_accept),  64'd1);
    chk("rst.mcmd_valid",   64'(o_mcmd_valid),   64'd0);
    chk("rst.mdata_valid",  64'(o_mdata_valid),  64'd0);
    chk("rst.sdata_accept", 64'(o_sdata_accept), 64'd0);
    chk("rst.mcmd",         64'(o_mcmd),         64'd0);
    chk("rst.mdata_last",   64'(o_mdata_last),   64'd0);
    chk("rst.busy",         64'(o_busy),         64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: idle, read length 3, write length 4 with data presented early.
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      mv = vec[i].mv; mw = vec[i].mw; ml = vec[i].ml; mc = vec[i].mc;
      sa_c = vec[i].sa_c; dv = vec[i].dv; d = vec[i].d; da = vec[i].da;
      #1;
      chk($sformatf("v%0d.scmd_accept", i),  64'(o_scmd_accept),  64'(vec[i].e_sacc));
      chk($sformatf("v%0d.mcmd_valid", i),   64'(o_mcmd_valid),   64'(vec[i].e_mv));
      chk($sformatf("v%0d.mdata_valid", i),  64'(o_mdata_valid),  64'(vec[i].e_dv));
      chk($sformatf("v%0d.sdata_accept", i), 64'(o_sdata_accept), 64'(vec[i].e_dacc));
      chk($sformatf("v%0d.busy", i),         64'(o_busy),         64'(vec[i].e_busy));
      if (vec[i].e_mv) begin
        chk($sformatf("v%0d.mcmd", i),        64'(o_mcmd),        64'(vec[i].e_mc));
        chk($sformatf("v%0d.mcmd_write", i),  64'(o_mcmd_write),  64'(vec[i].e_mw));
        chk($sformatf("v%0d.mcmd_length", i), 64'(o_mcmd_length), 64'(vec[i].e_ml));
      end
      if (vec[i].e_dv) begin
        chk($sformatf("v%0d.mdata", i),      o_mdata,             vec[i].e_d);
        chk($sformatf("v%0d.mdata_last", i), 64'(o_mdata_last),   64'(vec[i].e_last));
      end
    end

    // Length 0 write = 16 beats with random downstream stalls; a read is
    // queued behind it and must not be accepted before beat 16.
    @(negedge clk);
    mv = 1; mw = 1; ml = '0; mc = 32'hB0B0_0010; sa_c = 0; dv = 1; da = 0; d = '0;
    #1;
    chk("l0.issue_accept", 64'(o_scmd_accept), 64'd1);
    @(negedge clk);
    mv = 1; mw = 0; ml = 4'd2; mc = 32'hB0B0_0020; sa_c = 1;
    #1;
    chk("l0.mcmd_valid",  64'(o_mcmd_valid),  64'd1);
    chk("l0.mcmd",        64'(o_mcmd),        64'hB0B0_0010);
    chk("l0.mcmd_length", 64'(o_mcmd_length), 64'd0);
    chk("l0.mcmd_write",  64'(o_mcmd_write),  64'd1);
    beat = 0;
    cyc  = 0;
    while (beat < 16 && cyc < 200) begin
      @(negedge clk);
      sa_c = 0;
      da = 1'($urandom_range(0, 1));
      d  = 64'hF00D_0000_0000_0000 | 64'(beat);
      ed = 64'hF00D_0000_0000_0000 | 64'(beat);
      #1;
      chk("l0.mdata_valid",  64'(o_mdata_valid),  64'd1);
      chk("l0.sdata_accept", 64'(o_sdata_accept), 64'(da));
      chk("l0.mdata",        o_mdata,             ed);
      chk("l0.mdata_last",   64'(o_mdata_last),   64'(beat == 15));
      chk("l0.scmd_blocked", 64'(o_scmd_accept),  64'd0);
      if (da) beat++;
      cyc++;
    end
    chk("l0.beat_count", 64'(beat), 64'd16);
    @(negedge clk);
    da = 0; dv = 0;
    #1;
    chk("l0.after_accept", 64'(o_scmd_accept), 64'd1);
    chk("l0.after_busy",   64'(o_busy),        64'd0);
    chk("l0.after_dvalid", 64'(o_mdata_valid), 64'd0);
    @(negedge clk);
    mv = 0; sa_c = 1;
    #1;
    chk("l0.next_mcmd_valid", 64'(o_mcmd_valid), 64'd1);
    chk("l0.next_mcmd",       64'(o_mcmd),       64'hB0B0_0020);
    chk("l0.next_write",      64'(o_mcmd_write), 64'd0);
    @(negedge clk);
    sa_c = 0;
    #1;
    chk("l0.next_idle", 64'(o_busy), 64'd0);

    // Downstream command accept held low for 5 cycles, handshake on the 6th.
    @(negedge clk);
    mv = 1; mw = 1; ml = 4'd1; mc = 32'h3C3C_0001; sa_c = 0; dv = 1; d = 64'hABCD; da = 1;
    #1;
    chk("st.issue_accept", 64'(o_scmd_accept), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mv = 0; mc = 32'hFFFF_FFFF ^ 32'(k); sa_c = 0;
      #1;
      chk("st.mcmd_valid",  64'(o_mcmd_valid),  64'd1);
      chk("st.mcmd",        64'(o_mcmd),        64'h3C3C_0001);
      chk("st.scmd_accept", 64'(o_scmd_accept), 64'd0);
      chk("st.mdata_valid", 64'(o_mdata_valid), 64'd0);
    end
    @(negedge clk);
    sa_c = 1;
    #1;
    chk("st.hs_mcmd_valid", 64'(o_mcmd_valid), 64'd1);
    chk("st.hs_mcmd",       64'(o_mcmd),       64'h3C3C_0001);
    @(negedge clk);
    sa_c = 0;
    #1;
    chk("st.data_valid", 64'(o_mdata_valid), 64'd1);
    chk("st.data",       o_mdata,            64'hABCD);
    chk("st.data_last",  64'(o_mdata_last),  64'd1);
    @(negedge clk);
    dv = 0;
    #1;
    chk("st.idle", 64'(o_busy), 64'd0);

    // Reset in the middle of a 4-beat burst, after beat 2.
    @(negedge clk);
    mv = 1; mw = 1; ml = 4'd4; mc = 32'h7777_0004; sa_c = 1; dv = 1; da = 1; d = 64'h5500;
    @(negedge clk);
    mv = 0;
    #1;
    chk("rb.mcmd_valid", 64'(o_mcmd_valid), 64'd1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      d = 64'h5500 + 64'(b);
      #1;
      chk("rb.mdata_valid", 64'(o_mdata_valid), 64'd1);
      chk("rb.mdata",       o_mdata,             64'h5500 + 64'(b));
      chk("rb.mdata_last",  64'(o_mdata_last),   64'd0);
    end
    @(negedge clk);
    rst = 1'b1; d = 64'h5502;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rb.busy",         64'(o_busy),        64'd0);
    chk("rb.mdata_valid",  64'(o_mdata_valid), 64'd0);
    chk("rb.scmd_accept",  64'(o_scmd_accept), 64'd1);
    @(negedge clk);
    mv = 1; mw = 0; ml = 4'd1; mc = 32'h8888_0001; sa_c = 1;
    @(negedge clk);
    mv = 0;
    #1;
    chk("rb.rd_mcmd_valid", 64'(o_mcmd_valid), 64'd1);
    chk("rb.rd_mcmd",       64'(o_mcmd),       64'h8888_0001);
    chk("rb.rd_write",      64'(o_mcmd_write), 64'd0);
    @(negedge clk);
    #1;
    chk("rb.rd_idle",        64'(o_busy),        64'd0);
    chk("rb.rd_mcmd_gone",   64'(o_mcmd_valid),  64'd0);
    chk("rb.rd_data_gated",  64'(o_mdata_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
